gray_codec: RTL
===============

# gray_codec

Parametrised multi-lane Gray/binary codec for the demapper path. Each accepted beat carries LANES symbols of $clog2(MODULATION_ORDER) bits plus a per-beat direction (Gray→binary or binary→Gray) and an I/Q split flag for square QAM. The XOR chain is spread over a configurable number of pipeline stages with full valid/ready backpressure. A running output-symbol counter feeds link statistics.

## Interface
- MODULATION_ORDER, 16, constellation size; power of two, ≥2; W = $clog2(MODULATION_ORDER)
- LANES, 4, symbols per beat, ≥1
- PIPE_STAGES, 2, register stages, 1..W
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- i_dv  in  1  input beat valid
- i_ready  out  1  input beat accepted when i_dv & i_ready
- i_code  in  LANES*W  input symbols; lane n at [n*W +: W]
- i_mode  in  1  0 = Gray→binary, 1 = binary→Gray
- i_split  in  1  1 = treat each lane as independent I (upper W/2) and Q (lower W/2) fields
- o_dv  out  1  output beat valid
- o_ready  in  1  downstream ready
- o_code  out  LANES*W  converted symbols, same lane packing
- o_mode  out  1  mode of the beat on o_code
- i_clr  in  1  synchronous clear of o_sym_count
- o_sym_count  out  32  count of output beats transferred

## Operation
- Gray→binary per field: b[MSB] = g[MSB]; b[k] = b[k+1] ^ g[k].
- Binary→Gray per field: g[k] = b[k] ^ b[k+1]; g[MSB] = b[MSB].
- Field = whole lane (W bits) when i_split=0; two W/2 fields when i_split=1 and W even. i_split ignored (treated 0) when W odd.
- i_mode and i_split captured with the beat and travel down the pipeline; beats of different modes may be interleaved back-to-back.
- Stage s (1..PIPE_STAGES) holds valid flag v[s], partial code, mode, split. Prefix XOR chain partitioned so each stage has ≤ ceil(W/PIPE_STAGES) XOR levels; last stage register is the output register.
- Stage s loads when v[s]=0 or stage s+1 loads (stage PIPE_STAGES+1 = downstream: o_ready). i_ready = stage 1 load enable (combinational from o_ready).
- Registers of a stage not loading hold value; no beat dropped or duplicated.
- o_sym_count increments on o_dv & o_ready, wraps 2^32−1 → 0. i_clr sets it to 0; i_clr coincident with a transfer yields 1.

## Timing
- Reset: all v[s]=0, o_dv=0, o_code=0, o_mode=0, o_sym_count=0; i_ready=1 in first cycle after reset release.
- rst mid-operation: all in-flight beats discarded next cycle; no o_dv pulse follows.
- Latency: beat accepted at edge t appears on o_code/o_dv after edge t+PIPE_STAGES−1 when unstalled (PIPE_STAGES=1: valid right after acceptance edge).
- Throughput: one beat/cycle with o_ready held high.
- Stall: with o_ready=0, pipeline fills; i_ready drops after PIPE_STAGES beats accepted; o_code/o_mode stable while o_dv & !o_ready.
- Bubbles collapse: an empty stage accepts even if downstream stalled.

## Structure
- gray_codec_pkg: mode enum (MODE_G2B, MODE_B2G), function field_width(W, split), functions gray2bin_f/bin2gray_f over a parametrised vector.
- Sub-module gray_codec_stage: one elastic stage (valid/load logic + partial XOR levels), instantiated PIPE_STAGES times in a generate loop; top holds lane packing and counter.

## Test plan
- Reset then single beat, MODULATION_ORDER=16, lane0 i_code=4'b0110, i_mode=0, i_split=0 → o_code lane0 4'b0100, o_dv exactly PIPE_STAGES−1 cycles after accept edge, o_sym_count=1.
- Same lane 4'b0100, i_mode=1 → 4'b0110; i_split=1, i_mode=0, 4'b0110 → 4'b0111.
- Exhaustive 0..15 per lane, alternating modes back-to-back, o_ready=1 → one output/cycle, each matches model, round-trip G2B(B2G(x))=x.
- o_ready=0 for 10 cycles while i_dv=1 → exactly PIPE_STAGES beats accepted, o_code stable; release → order preserved, no loss/duplication.
- o_sym_count preset near wrap via 2^32−1 transfers (forced) → wraps to 0; i_clr with simultaneous transfer → 1.
- rst asserted with pipeline full → next cycle o_dv=0, o_code=0, i_ready=1, no stale beat emerges.

Source files
------------

// File: rtl/gray_codec_pkg.sv
// rtl/gray_codec_pkg.sv - shared types and field helpers for the Gray/binary codec
package gray_codec_pkg;

   typedef enum logic {
      MODE_G2B = 1'b0,
      MODE_B2G = 1'b1
   } mode_e;

   localparam int MAX_W = 32;
   localparam int CNT_W = 32;

   // Split only applies to even widths; odd widths fall back to whole-lane fields.
   function automatic int field_width(input int w, input logic split);
      return (split && (w % 2 == 0)) ? w / 2 : w;
   endfunction

   function automatic logic [MAX_W-1:0] gray2bin_f(input logic [MAX_W-1:0] g, input int fw);
      logic [MAX_W-1:0] b;
      b = '0;
      if (fw > 0) b[fw-1] = g[fw-1];
      for (int k = MAX_W - 2; k >= 0; k--) begin
         if (k < fw - 1) b[k] = b[k+1] ^ g[k];
      end
      return b;
   endfunction

   function automatic logic [MAX_W-1:0] bin2gray_f(input logic [MAX_W-1:0] b, input int fw);
      logic [MAX_W-1:0] g;
      g = '0;
      if (fw > 0) g[fw-1] = b[fw-1];
      for (int k = 0; k < MAX_W - 1; k++) begin
         if (k < fw - 1) g[k] = b[k] ^ b[k+1];
      end
      return g;
   endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// rtl/gray_codec_stage.sv - one elastic pipeline stage carrying a slice of the XOR chain
module gray_codec_stage
   import gray_codec_pkg::*;
#(
   parameter int W      = 4,
   parameter int LANES  = 4,
   parameter int STAGE  = 0,
   parameter int LEVELS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_valid,
   input  logic [LANES*W-1:0]   up_code,
   input  logic                 up_mode,
   input  logic                 up_split,
   input  logic                 down_load,
   output logic                 valid,
   output logic [LANES*W-1:0]   code,
   output logic                 mode,
   output logic                 split
);

   // Chain depth j counts bits below a field's MSB; this stage resolves depths LO_J..HI_J.
   localparam int LO_J = STAGE * LEVELS + 1;
   localparam int HI_J = (STAGE + 1) * LEVELS;

   logic                 load;
   logic [LANES*W-1:0]   next_code;

   assign load = !valid || down_load;

   always_comb begin
      int fw;
      int ftop;
      int j;
      next_code = up_code;
      fw        = field_width(W, up_split);
      ftop      = 0;
      j         = 0;
      for (int n = 0; n < LANES; n++) begin
         // Descending k lets each bit see the already-resolved bit above it.
         for (int k = W - 2; k >= 0; k--) begin
            ftop = (k >= fw) ? 2 * fw - 1 : fw - 1;
            j    = ftop - k;
            if (k != ftop) begin
               if (mode_e'(up_mode) == MODE_G2B) begin
                  if (j >= LO_J && j <= HI_J)
                     next_code[n*W+k] = next_code[n*W+k+1] ^ next_code[n*W+k];
               end else if (STAGE == 0) begin
                  next_code[n*W+k] = up_code[n*W+k] ^ up_code[n*W+k+1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         code  <= '0;
         mode  <= 1'b0;
         split <= 1'b0;
      end else if (load) begin
         valid <= up_valid;
         code  <= next_code;
         mode  <= up_mode;
         split <= up_split;
      end
   end

endmodule

// File: rtl/gray_codec.sv
// rtl/gray_codec.sv - multi-lane pipelined Gray/binary codec with output beat counter
module gray_codec
   import gray_codec_pkg::*;
#(
   parameter int MODULATION_ORDER = 16,
   parameter int LANES            = 4,
   parameter int PIPE_STAGES      = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_dv,
   output logic                                   i_ready,
   input  logic [LANES*$clog2(MODULATION_ORDER)-1:0] i_code,
   input  logic                                   i_mode,
   input  logic                                   i_split,
   output logic                                   o_dv,
   input  logic                                   o_ready,
   output logic [LANES*$clog2(MODULATION_ORDER)-1:0] o_code,
   output logic                                   o_mode,
   input  logic                                   i_clr,
   output logic [31:0]                            o_sym_count
);

   localparam int W      = $clog2(MODULATION_ORDER);
   localparam int LEVELS = (W + PIPE_STAGES - 1) / PIPE_STAGES;

   // Index 0 is the input port; index s+1 is the register of stage s.
   logic [PIPE_STAGES:0][LANES*W-1:0] code_p;
   logic [PIPE_STAGES:0]              valid_p;
   logic [PIPE_STAGES:0]              mode_p;
   logic [PIPE_STAGES:0]              split_p;
   logic [PIPE_STAGES-1:0]            down_load;
   logic                              unused_split;
   logic [CNT_W-1:0]                  sym_count;
   logic                              out_xfer;

   assign code_p[0]  = i_code;
   assign valid_p[0] = i_dv;
   assign mode_p[0]  = i_mode;
   assign split_p[0] = i_split;

   // The successor of stage s loads if any later stage is empty or downstream is ready;
   // deriving it from the valid flags avoids a combinational chain through the stages.
   always_comb begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
         down_load[s] = o_ready;
         for (int k = s + 1; k < PIPE_STAGES; k++) begin
            if (!valid_p[k+1]) down_load[s] = 1'b1;
         end
      end
      i_ready = down_load[0] || !valid_p[1];
   end

   for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      gray_codec_stage #(
         .W      (W),
         .LANES  (LANES),
         .STAGE  (s),
         .LEVELS (LEVELS)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .up_valid  (valid_p[s]),
         .up_code   (code_p[s]),
         .up_mode   (mode_p[s]),
         .up_split  (split_p[s]),
         .down_load (down_load[s]),
         .valid     (valid_p[s+1]),
         .code      (code_p[s+1]),
         .mode      (mode_p[s+1]),
         .split     (split_p[s+1])
      );
   end

   assign unused_split = split_p[PIPE_STAGES];

   assign o_dv   = valid_p[PIPE_STAGES];
   assign o_code = code_p[PIPE_STAGES];
   assign o_mode = mode_p[PIPE_STAGES];

   assign out_xfer = o_dv && o_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         sym_count <= '0;
      end else if (i_clr) begin
         sym_count <= out_xfer ? CNT_W'(1) : '0;
      end else if (out_xfer) begin
         sym_count <= sym_count + CNT_W'(1);
      end
   end

   assign o_sym_count = sym_count;

endmodule
